// File: rtl/spi_slave.sv
// SPI mode-0 slave: synchronizes the SPI pins into clk, shifts frames MSB first,
// and reports complete words (rx_valid) or malformed frames (frame_err).
module spi_slave #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    OVERRUN = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
  logic                    sclk_hist_q, sclk_hist_d;
  logic                    cs_hist_q, cs_hist_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic [DATA_WIDTH-1:0]   tx_buf_q, tx_buf_d;
  logic                    tx_full_q, tx_full_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    frame_err_q, frame_err_d;

  logic                    sclk_s, cs_s, mosi_s;
  logic                    sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic                    load_accept;
  logic [DATA_WIDTH-1:0]   rx_word;

  // The cs_n chain resets to 0 (as if selected) so that a release of reset
  // in the middle of a frame cannot fake a falling edge of chip select.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sclk_hist_d = sclk_s;
    cs_hist_d   = cs_s;
    sclk_rise   = sclk_s & ~sclk_hist_q;
    sclk_fall   = ~sclk_s & sclk_hist_q;
    cs_fall     = ~cs_s & cs_hist_q;
    cs_rise     = cs_s & ~cs_hist_q;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    tx_buf_d    = tx_buf_q;
    tx_full_d   = tx_full_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    load_accept = tx_load & ~tx_full_q;
    rx_word     = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};

    if (load_accept) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // A load arriving with the frame start goes straight to the wire
        // and never occupies the buffer.
        if (cs_fall) begin
          state_d    = ACTIVE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          tx_full_d  = 1'b0;
          if (tx_full_q) begin
            tx_shift_d = tx_buf_q;
          end else if (load_accept) begin
            tx_shift_d = tx_data;
          end else begin
            tx_shift_d = '0;
          end
        end
      end

      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          if ((bit_cnt_q != '0) && (bit_cnt_q < CNT_W'(DATA_WIDTH))) begin
            frame_err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          if (bit_cnt_q == CNT_W'(DATA_WIDTH)) begin
            state_d     = OVERRUN;
            frame_err_d = 1'b1;
          end else begin
            rx_shift_d = rx_word;
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
              rx_data_d  = rx_word;
              rx_valid_d = 1'b1;
            end
          end
        end else if (sclk_fall) begin
          tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
        end
      end

      OVERRUN: begin
        if (cs_rise) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b0;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_hist_q <= sclk_hist_d;
      cs_hist_q   <= cs_hist_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign miso      = ~cs_s & tx_shift_q[DATA_WIDTH-1];
  assign tx_ready  = ~tx_full_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a vector table of whole frames plus hand-written
// sequences for double loads, load at frame start and reset mid-frame.
module tb_spi_slave;

  localparam int HALF = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [15:0] tx_data = '0;
  logic        tx_load = 1'b0;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        frame_err;

  int checks = 0;
  int fails = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  spi_slave #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Counts every cycle a pulse is high, so a stretched pulse shows up as extra.
  always @(negedge clk) begin
    if (rx_valid) valid_cnt++;
    if (frame_err) err_cnt++;
  end

  typedef struct {
    logic        do_load;
    logic [15:0] load_word;
    logic [31:0] mosi_word;
    int          edges;
    logic [15:0] exp_rx;
    logic [15:0] exp_miso;
    int          exp_valid;
    int          exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic load_word(input logic [15:0] word);
    @(negedge clk);
    tx_data = word;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    @(negedge clk);
  endtask

  // One master frame: mosi_word holds the bits to send, last edge in bit 0.
  // Returns the first 16 miso bits sampled before each rising edge.
  task automatic apply_stimulus(input logic [31:0] mosi_word, input int edges,
                                input bit load_at_fall, input logic [15:0] fall_word,
                                output logic [15:0] miso16);
    logic [31:0] sampled;
    sampled = '0;
    @(negedge clk);
    cs_n = 1'b0;
    mosi = mosi_word[edges-1];
    if (load_at_fall) begin
      repeat (2) @(negedge clk);
      tx_data = fall_word;
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
      repeat (HALF - 3) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    for (int i = 0; i < edges; i++) begin
      sampled = {sampled[30:0], miso};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      if (i + 1 < edges) mosi = mosi_word[edges-2-i];
      repeat (HALF) @(negedge clk);
    end
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
    if (edges >= 16) miso16 = 16'(sampled >> (edges - 16));
    else miso16 = 16'(sampled << (16 - edges));
  endtask

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] m16;
    int v0, e0;

    vecs[0] = '{1'b1, 16'h1234, 32'h0000A5C3, 16, 16'hA5C3, 16'h1234, 1, 0};
    vecs[1] = '{1'b0, 16'h0000, 32'h000000FF, 16, 16'h00FF, 16'h0000, 1, 0};
    vecs[2] = '{1'b0, 16'h0000, 32'h0000FF00, 16, 16'hFF00, 16'h0000, 1, 0};
    vecs[3] = '{1'b0, 16'h0000, 32'h000000C3, 8,  16'hFF00, 16'h0000, 0, 1};
    vecs[4] = '{1'b1, 16'h1357, 32'h000048D1, 17, 16'h2468, 16'h1357, 1, 1};

    repeat (4) @(negedge clk);
    check_output("reset_rx_data", 32'(rx_data), 32'h0);
    check_output("reset_tx_ready", 32'(tx_ready), 32'h1);
    check_output("reset_miso", 32'(miso), 32'h0);
    check_output("reset_rx_valid", 32'(rx_valid), 32'h0);
    check_output("reset_frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      if (vecs[k].do_load) begin
        load_word(vecs[k].load_word);
        check_output($sformatf("vec%0d_ready_after_load", k), 32'(tx_ready), 32'h0);
      end
      v0 = valid_cnt;
      e0 = err_cnt;
      apply_stimulus(vecs[k].mosi_word, vecs[k].edges, 1'b0, 16'h0, m16);
      check_output($sformatf("vec%0d_rx_data", k), 32'(rx_data), 32'(vecs[k].exp_rx));
      check_output($sformatf("vec%0d_miso", k), 32'(m16), 32'(vecs[k].exp_miso));
      check_output($sformatf("vec%0d_rx_valid_cycles", k), valid_cnt - v0, vecs[k].exp_valid);
      check_output($sformatf("vec%0d_frame_err_cycles", k), err_cnt - e0, vecs[k].exp_err);
      check_output($sformatf("vec%0d_tx_ready", k), 32'(tx_ready), 32'h1);
    end

    // Second load while the buffer is full must be dropped.
    load_word(16'hBEEF);
    check_output("dbl_ready_after_first", 32'(tx_ready), 32'h0);
    load_word(16'h5555);
    apply_stimulus(32'h0F0F, 16, 1'b0, 16'h0, m16);
    check_output("dbl_miso", 32'(m16), 32'hBEEF);
    check_output("dbl_rx_data", 32'(rx_data), 32'h0F0F);
    check_output("dbl_tx_ready", 32'(tx_ready), 32'h1);
    apply_stimulus(32'hF0F0, 16, 1'b0, 16'h0, m16);
    check_output("dbl_second_dropped_miso", 32'(m16), 32'h0);

    // Load in the same cycle as the frame start is sent immediately.
    apply_stimulus(32'h3C3C, 16, 1'b1, 16'hC001, m16);
    check_output("fall_load_miso", 32'(m16), 32'hC001);
    check_output("fall_load_tx_ready", 32'(tx_ready), 32'h1);
    apply_stimulus(32'h1111, 16, 1'b0, 16'h0, m16);
    check_output("fall_load_buffer_empty_miso", 32'(m16), 32'h0);

    // Reset after bit 5, released while cs_n is still low.
    @(negedge clk);
    cs_n = 1'b0;
    mosi = 1'b1;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("midrst_rx_data", 32'(rx_data), 32'h0);
    check_output("midrst_tx_ready", 32'(tx_ready), 32'h1);
    check_output("midrst_miso", 32'(miso), 32'h0);
    check_output("midrst_rx_valid", 32'(rx_valid), 32'h0);
    check_output("midrst_frame_err", 32'(frame_err), 32'h0);
    v0 = valid_cnt;
    e0 = err_cnt;
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
    check_output("midrst_no_valid", valid_cnt - v0, 0);
    check_output("midrst_no_err", err_cnt - e0, 0);
    check_output("midrst_rx_unchanged", 32'(rx_data), 32'h0);
    v0 = valid_cnt;
    e0 = err_cnt;
    apply_stimulus(32'h5A5A, 16, 1'b0, 16'h0, m16);
    check_output("postrst_rx_data", 32'(rx_data), 32'h5A5A);
    check_output("postrst_valid", valid_cnt - v0, 1);
    check_output("postrst_err", err_cnt - e0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
